multicycle_ctrl: RTL and testbench

Multicycle control FSM for the 16-bit CPU. It replaces the single-cycle main decoder when the datapath shares one memory port and one ALU across several cycles per instruction. It sequences fetch, decode, execute, memory and writeback, and produces the datapath select and enable signals each cycle. It holds in memory states until the memory handshake completes.

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mc_outdec.sv | 102 ++++++++++
 rtl/multicycle_ctrl.sv | 87 ++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared opcodes, ALU op codes, state encoding and the control bundle
// used by the multicycle controller and its output decoder.
package mc_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW    = 3'b001;
  localparam logic [2:0] OP_SW    = 3'b010;
  localparam logic [2:0] OP_BEQ   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BRO = 2'b11;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    BEQ,
    ADDIEX,
    ADDIWB,
    JUMP
  } statetype_t;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       memwrite;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state-to-control decoder for the multicycle controller.
// hold squashes every enable while leaving the mux selects intact.
module mc_outdec
  import mc_pkg::*;
(
  input  statetype_t state,
  input  logic [2:0] op,
  input  logic       mem_ready,
  input  logic       hold,
  output ctrl_t      ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    unique case (state)
      FETCH: begin
        c.mem_req = 1'b1;
        c.alusrcb = SRCB_ONE;
        c.aluop   = ALUOP_ADD;
        c.pcsrc   = PCSRC_ALU;
        c.irwrite = mem_ready;
        c.pcwrite = mem_ready;
      end
      DECODE: begin
        c.alusrcb    = SRCB_BRO;
        c.aluop      = ALUOP_ADD;
        c.illegal    = op_illegal(op);
        c.instr_done = op_illegal(op);
      end
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      MEMWB: begin
        c.memtoreg   = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      MEMWR: begin
        c.mem_req    = 1'b1;
        c.iord       = 1'b1;
        c.memwrite   = mem_ready;
        c.instr_done = mem_ready;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_REG;
        c.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.regdst     = 1'b1;
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      BEQ: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = SRCB_REG;
        c.aluop      = ALUOP_SUB;
        c.pcsrc      = PCSRC_OUT;
        c.branch     = 1'b1;
        c.instr_done = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_ADD;
      end
      ADDIWB: begin
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      JUMP: begin
        c.pcsrc      = PCSRC_JUMP;
        c.pcwrite    = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
  end

  always_comb begin
    ctrl = c;
    if (hold) begin
      ctrl.mem_req    = 1'b0;
      ctrl.irwrite    = 1'b0;
      ctrl.pcwrite    = 1'b0;
      ctrl.regwrite   = 1'b0;
      ctrl.memwrite   = 1'b0;
      ctrl.branch     = 1'b0;
      ctrl.instr_done = 1'b0;
      ctrl.illegal    = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: state register and next-state logic; the
// per-state datapath controls come from mc_outdec.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       memwrite,
  output logic       instr_done,
  output logic       illegal
);

  statetype_t state_q, state_d, dec_state;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (op)
          OP_RTYPE:     state_d = EXECUTE;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BEQ;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (mem_ready) state_d = MEMWB;
      MEMWR:   if (mem_ready) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // During reset the selects show FETCH values whatever the register holds
  assign dec_state = reset ? FETCH : state_q;

  mc_outdec u_outdec (
    .state     (dec_state),
    .op        (op),
    .mem_ready (mem_ready),
    .hold      (reset),
    .ctrl      (ctrl)
  );

  always_comb begin
    mem_req    = ctrl.mem_req;
    iord       = ctrl.iord;
    irwrite    = ctrl.irwrite;
    pcwrite    = ctrl.pcwrite;
    branch     = ctrl.branch;
    pcsrc      = ctrl.pcsrc;
    alusrca    = ctrl.alusrca;
    alusrcb    = ctrl.alusrcb;
    aluop      = ctrl.aluop;
    regdst     = ctrl.regdst;
    memtoreg   = ctrl.memtoreg;
    regwrite   = ctrl.regwrite;
    memwrite   = ctrl.memwrite;
    instr_done = ctrl.instr_done;
    illegal    = ctrl.illegal;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus
// instruction cycle counts and a reset-during-store sequence.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] op = 3'b000;
  logic       mem_ready = 1'b1;
  logic       mem_req, iord, irwrite, pcwrite, branch;
  logic [1:0] pcsrc, alusrcb, aluop;
  logic       alusrca, regdst, memtoreg, regwrite, memwrite;
  logic       instr_done, illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .iord       (iord),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .branch     (branch),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .instr_done (instr_done),
    .illegal    (illegal)
  );

  logic [17:0] act;
  assign act = {mem_req, iord, irwrite, pcwrite, branch, pcsrc,
                alusrca, alusrcb, aluop, regdst, memtoreg,
                regwrite, memwrite, instr_done, illegal};

  localparam logic [17:0] MREQ = 18'd1 << 17;
  localparam logic [17:0] IORD = 18'd1 << 16;
  localparam logic [17:0] IRW  = 18'd1 << 15;
  localparam logic [17:0] PCW  = 18'd1 << 14;
  localparam logic [17:0] BR   = 18'd1 << 13;
  localparam logic [17:0] PSO  = 18'd1 << 11;
  localparam logic [17:0] PSJ  = 18'd2 << 11;
  localparam logic [17:0] SRCA = 18'd1 << 10;
  localparam logic [17:0] SB1  = 18'd1 << 8;
  localparam logic [17:0] SBI  = 18'd2 << 8;
  localparam logic [17:0] SBB  = 18'd3 << 8;
  localparam logic [17:0] ASUB = 18'd1 << 6;
  localparam logic [17:0] AFN  = 18'd2 << 6;
  localparam logic [17:0] RDST = 18'd1 << 5;
  localparam logic [17:0] M2R  = 18'd1 << 4;
  localparam logic [17:0] RW   = 18'd1 << 3;
  localparam logic [17:0] MW   = 18'd1 << 2;
  localparam logic [17:0] DONE = 18'd1 << 1;
  localparam logic [17:0] ILL  = 18'd1;

  localparam logic [17:0] E_RST   = SB1;
  localparam logic [17:0] E_FW    = MREQ | SB1;
  localparam logic [17:0] E_F     = MREQ | IRW | PCW | SB1;
  localparam logic [17:0] E_DEC   = SBB;
  localparam logic [17:0] E_DILL  = SBB | DONE | ILL;
  localparam logic [17:0] E_MADR  = SRCA | SBI;
  localparam logic [17:0] E_MRD   = MREQ | IORD;
  localparam logic [17:0] E_MWB   = M2R | RW | DONE;
  localparam logic [17:0] E_MWRW  = MREQ | IORD;
  localparam logic [17:0] E_MWR   = MREQ | IORD | MW | DONE;
  localparam logic [17:0] E_EXE   = SRCA | AFN;
  localparam logic [17:0] E_AWB   = RDST | RW | DONE;
  localparam logic [17:0] E_BEQ   = SRCA | ASUB | PSO | BR | DONE;
  localparam logic [17:0] E_AEX   = SRCA | SBI;
  localparam logic [17:0] E_AWB2  = RW | DONE;
  localparam logic [17:0] E_JMP   = PSJ | PCW | DONE;

  typedef struct {
    logic        rst;
    logic [2:0]  op;
    logic        mr;
    logic [17:0] exp;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [2:0] o,
                     input logic m, input logic [17:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.exp = e;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic cyc(input logic r, input logic [2:0] o, input logic m);
    @(negedge clk);
    reset = r; op = o; mem_ready = m;
    #1;
  endtask

  task automatic run_instr(input logic [2:0] o, input int want);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      cyc(1'b0, o, 1'b1);
      n++;
      seen = instr_done;
    end
    chk($sformatf("cycles op%0d", o), n, want);
  endtask

  initial begin
    // reset, then R-type
    add(1, 3'd0, 1, E_RST);
    add(1, 3'd0, 1, E_RST);
    add(0, 3'd0, 1, E_F);
    add(0, 3'd0, 1, E_DEC);
    add(0, 3'd0, 1, E_EXE);
    add(0, 3'd0, 1, E_AWB);
    // lw, two waits in MEMRD
    add(0, 3'd1, 1, E_F);
    add(0, 3'd1, 1, E_DEC);
    add(0, 3'd1, 1, E_MADR);
    add(0, 3'd1, 0, E_MRD);
    add(0, 3'd1, 0, E_MRD);
    add(0, 3'd1, 1, E_MRD);
    add(0, 3'd1, 1, E_MWB);
    // sw, one wait in FETCH
    add(0, 3'd2, 0, E_FW);
    add(0, 3'd2, 1, E_F);
    add(0, 3'd2, 1, E_DEC);
    add(0, 3'd2, 1, E_MADR);
    add(0, 3'd2, 1, E_MWR);
    // beq, j
    add(0, 3'd3, 1, E_F);
    add(0, 3'd3, 1, E_DEC);
    add(0, 3'd3, 1, E_BEQ);
    add(0, 3'd5, 1, E_F);
    add(0, 3'd5, 1, E_DEC);
    add(0, 3'd5, 1, E_JMP);
    // addi, then illegal 110 and 111
    add(0, 3'd4, 1, E_F);
    add(0, 3'd4, 1, E_DEC);
    add(0, 3'd4, 1, E_AEX);
    add(0, 3'd4, 1, E_AWB2);
    add(0, 3'd6, 1, E_F);
    add(0, 3'd6, 1, E_DILL);
    add(0, 3'd7, 1, E_F);
    add(0, 3'd7, 1, E_DILL);
    // mem_ready ignored outside memory states
    add(0, 3'd0, 1, E_F);
    add(0, 3'd0, 0, E_DEC);
    add(0, 3'd0, 0, E_EXE);
    add(0, 3'd0, 0, E_AWB);
    // reset in the middle of DECODE of an illegal op
    add(0, 3'd6, 1, E_F);
    add(1, 3'd6, 1, E_RST);
    add(0, 3'd6, 1, E_F);
    add(0, 3'd6, 1, E_DILL);

    foreach (tv[i]) begin
      cyc(tv[i].rst, tv[i].op, tv[i].mr);
      chk($sformatf("vec%0d", i), act, tv[i].exp);
    end

    run_instr(3'd0, 4);
    run_instr(3'd1, 5);
    run_instr(3'd2, 4);
    run_instr(3'd3, 3);
    run_instr(3'd4, 4);
    run_instr(3'd5, 3);
    run_instr(3'd6, 2);

    // reset while the store waits on memory
    cyc(0, 3'd2, 1);
    cyc(0, 3'd2, 1);
    cyc(0, 3'd2, 1);
    cyc(0, 3'd2, 0);
    chk("sw wait", act, E_MWRW);
    cyc(1, 3'd2, 1);
    chk("rst memwrite", memwrite, 0);
    chk("rst outputs", act, E_RST);
    cyc(0, 3'd2, 0);
    chk("post rst memwrite", memwrite, 0);
    chk("post rst fetch", act, E_FW);
    cyc(0, 3'd2, 1);
    chk("post rst fetch rdy", act, E_F);
    cyc(0, 3'd2, 1);
    chk("post rst decode", act, E_DEC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
